quadrature_decoder: RTL and testbench

Converts a 2-phase quadrature encoder signal pair (enc_a, enc_b) into single-cycle up/down step pulses. The up/down outputs drive the up/down inputs of the team's up/down counter directly. The block provides:
- input synchronisation and per-channel glitch filtering;
- Gray-step decoding;
- illegal-transition (double-step) error reporting.

`up` and `down` are never asserted together.

---
 rtl/quad_pkg.sv | 39 +++
 rtl/quad_glitch_filter.sv | 51 +++++
 rtl/quadrature_decoder.sv | 141 ++++++++++++++
 tb/tb_quadrature_decoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and step decode for the quadrature decoder.
// Gray positions are mapped to binary so a step is a modular distance.
package quad_pkg;

    typedef enum logic {
        Q_UNPRIMED,
        Q_TRACK
    } quad_state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } quad_step_t;

    // 00,01,11,10 -> 0,1,2,3
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // +1 is forward, -1 is reverse, +2 is a skipped position
    function automatic quad_step_t quad_step(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        logic [1:0] w_d;
        quad_step_t w_s;
        w_d = gray2bin(cur) - gray2bin(prev);
        unique case (w_d)
            2'd0:    w_s = STEP_NONE;
            2'd1:    w_s = STEP_FWD;
            2'd2:    w_s = STEP_ERR;
            default: w_s = STEP_REV;
        endcase
        return w_s;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: metastability synchroniser plus
// persistence filter that accepts a level after FILT_LEN samples.
module quad_glitch_filter
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_filt
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [CW-1:0]          r_cnt;
    logic                   w_s;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign o_filt = r_filt;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    // Count consecutive differing samples; accept on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (w_s != r_filt) begin
            if (r_cnt == CW'(FILT_LEN - 1)) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder to up/down step pulses with error reporting.
// Waits out the filter pipeline after reset before decoding.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       en,
    input  logic       err_clr,
    output logic       up,
    output logic       down,
    output logic       dir,
    output logic       err,
    output logic       err_flag,
    output logic [1:0] phase
);

    localparam int PRIME_LEN = SYNC_STAGES + FILT_LEN + 1;
    localparam int PCW       = $clog2(PRIME_LEN + 1);

    logic        w_filt_a;
    logic        w_filt_b;
    logic [1:0]  w_cur;
    quad_step_t  w_step;

    quad_state_t r_state;
    quad_state_t w_state_nxt;
    logic [PCW-1:0] r_prime;
    logic [PCW-1:0] w_prime_nxt;
    logic [1:0]  r_prev;
    logic [1:0]  w_prev_nxt;
    logic        r_up;
    logic        r_down;
    logic        r_dir;
    logic        r_err;
    logic        r_flag;
    logic        w_up_nxt;
    logic        w_down_nxt;
    logic        w_dir_nxt;
    logic        w_err_nxt;
    logic        w_flag_nxt;

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .i_din (enc_a),
        .o_filt(w_filt_a)
    );

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .i_din (enc_b),
        .o_filt(w_filt_b)
    );

    assign w_cur    = {w_filt_a, w_filt_b};
    assign phase    = w_cur;
    assign up       = r_up;
    assign down     = r_down;
    assign dir      = r_dir;
    assign err      = r_err;
    assign err_flag = r_flag;

    // Next state, prime timer, step classification and output values
    always_comb begin
        w_state_nxt = r_state;
        w_prime_nxt = r_prime;
        w_prev_nxt  = r_prev;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_dir_nxt   = r_dir;
        w_flag_nxt  = err_clr ? 1'b0 : r_flag;
        w_step      = quad_step(r_prev, w_cur);
        unique case (r_state)
            Q_UNPRIMED: begin
                if (r_prime == PCW'(PRIME_LEN - 1)) begin
                    w_state_nxt = Q_TRACK;
                    w_prev_nxt  = w_cur;
                end else begin
                    w_prime_nxt = r_prime + 1'b1;
                end
            end
            Q_TRACK: begin
                w_prev_nxt = w_cur;
                unique case (w_step)
                    STEP_FWD: begin
                        w_up_nxt  = en;
                        w_dir_nxt = 1'b1;
                    end
                    STEP_REV: begin
                        w_down_nxt = en;
                        w_dir_nxt  = 1'b0;
                    end
                    STEP_ERR: begin
                        w_err_nxt  = 1'b1;
                        w_flag_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Register FSM state, previous phase and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= Q_UNPRIMED;
            r_prime <= '0;
            r_prev  <= 2'b00;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_dir   <= 1'b1;
            r_err   <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prime <= w_prime_nxt;
            r_prev  <= w_prev_nxt;
            r_up    <= w_up_nxt;
            r_down  <= w_down_nxt;
            r_dir   <= w_dir_nxt;
            r_err   <= w_err_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed plan then random walk,
// predicted from encoder positions and the fixed decode latency.
module tb_quadrature_decoder;

    localparam int MAXC = 16384;
    localparam int LAT  = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic       en;
    logic       err_clr;
    logic       up;
    logic       down;
    logic       dir;
    logic       err;
    logic       err_flag;
    logic [1:0] phase;

    quadrature_decoder #(
        .SYNC_STAGES(2),
        .FILT_LEN   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .en      (en),
        .err_clr (err_clr),
        .up      (up),
        .down    (down),
        .dir     (dir),
        .err     (err),
        .err_flag(err_flag),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int n_up   = 0;
    int n_dn   = 0;
    int n_err  = 0;

    logic en_e;
    logic clr_e;

    // step_at: 0 none, 1 forward, 2 reverse, 3 error
    bit [1:0] step_at [MAXC];
    bit       ph_v    [MAXC];
    bit [1:0] ph_val  [MAXC];

    logic       m_up;
    logic       m_dn;
    logic       m_err;
    logic       m_dir;
    logic       m_flag;
    logic [1:0] m_phase;
    logic [1:0] m_enc;

    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int gidx(input logic [1:0] v);
        for (int i = 0; i < 4; i++)
            if (seq[i] == v) return i;
        return 0;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got,
                        input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_up    = 1'b0;
        m_dn    = 1'b0;
        m_err   = 1'b0;
        m_dir   = 1'b1;
        m_flag  = 1'b0;
        m_phase = 2'b00;
    endtask

    task automatic check_all(input string pfx);
        chk1({pfx, "_up"},   up,       m_up);
        chk1({pfx, "_down"}, down,     m_dn);
        chk1({pfx, "_err"},  err,      m_err);
        chk1({pfx, "_dir"},  dir,      m_dir);
        chk1({pfx, "_flag"}, err_flag, m_flag);
        chk2({pfx, "_phase"}, phase,   m_phase);
    endtask

    task automatic tick();
        bit [1:0] s;
        @(posedge clk);
        cyc++;
        en_e  = en;
        clr_e = err_clr;
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            s = step_at[cyc];
            step_at[cyc] = 2'd0;
            m_up  = (s == 2'd1) && en_e;
            m_dn  = (s == 2'd2) && en_e;
            m_err = (s == 2'd3);
            if (s == 2'd1) m_dir = 1'b1;
            if (s == 2'd2) m_dir = 1'b0;
            if (s == 2'd3) m_flag = 1'b1;
            else if (clr_e) m_flag = 1'b0;
            if (ph_v[cyc]) m_phase = ph_val[cyc];
            ph_v[cyc] = 1'b0;
        end
        if (up === 1'b1)  n_up++;
        if (down === 1'b1) n_dn++;
        if (err === 1'b1) n_err++;
        check_all("cyc");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Move the encoder to v and predict the resulting pulse and phase
    task automatic sched(input logic [1:0] v);
        int d;
        if (cyc + LAT >= MAXC) begin
            $display("FAIL sched_overflow cyc=%0d", cyc);
            $fatal(1, "schedule table exhausted");
        end
        d = (gidx(v) - gidx(m_enc) + 4) % 4;
        step_at[cyc+LAT] = (d == 0) ? 2'd0 :
                           (d == 1) ? 2'd1 :
                           (d == 3) ? 2'd2 : 2'd3;
        if (d != 0) begin
            ph_v[cyc+LAT-1]   = 1'b1;
            ph_val[cyc+LAT-1] = v;
        end
        m_enc = v;
        {enc_a, enc_b} = v;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int c = cyc + 1; c < MAXC; c++) begin
            step_at[c] = 2'd0;
            ph_v[c]    = 1'b0;
        end
        check_all("rst_async");
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        if (m_enc != 2'b00) begin
            ph_v[cyc+LAT-1]   = 1'b1;
            ph_val[cyc+LAT-1] = m_enc;
        end
    endtask

    int b_up;
    int b_dn;
    int b_er;
    int gap;
    int rr;
    int delta;

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        err_clr = 1'b0;
        m_enc   = 2'b11;
        {enc_a, enc_b} = 2'b11;
        model_reset();
        ticks(3);

        // Priming window with A=B=1: no pulses, phase settles to 11
        release_reset();
        b_up = n_up; b_dn = n_dn; b_er = n_err;
        ticks(7);
        chki("prime_pulses", (n_up - b_up) + (n_dn - b_dn) + (n_err - b_er), 0);
        chk2("prime_phase", phase, 2'b11);
        ticks(5);

        // Walk forward to 00
        sched(2'b10); ticks(20);
        sched(2'b00); ticks(20);

        // Forward sweep
        b_up = n_up; b_dn = n_dn;
        sched(2'b01); ticks(20);
        sched(2'b11); ticks(20);
        sched(2'b10); ticks(20);
        sched(2'b00); ticks(20);
        chki("fwd_ups", n_up - b_up, 4);
        chki("fwd_downs", n_dn - b_dn, 0);
        chk1("fwd_dir", dir, 1'b1);

        // Reverse sweep
        b_up = n_up; b_dn = n_dn;
        sched(2'b10); ticks(20);
        sched(2'b11); ticks(20);
        sched(2'b01); ticks(20);
        sched(2'b00); ticks(20);
        chki("rev_downs", n_dn - b_dn, 4);
        chki("rev_ups", n_up - b_up, 0);
        chk1("rev_dir", dir, 1'b0);

        // Disabled steps tracked silently, then one enabled step
        b_up = n_up; b_dn = n_dn;
        en = 1'b0;
        sched(2'b01); ticks(20);
        sched(2'b11); ticks(20);
        chki("en0_pulses", (n_up - b_up) + (n_dn - b_dn), 0);
        chk2("en0_phase", phase, 2'b11);
        en = 1'b1;
        b_up = n_up;
        sched(2'b10); ticks(20);
        chki("en1_ups", n_up - b_up, 1);
        sched(2'b00); ticks(20);

        // 3-cycle glitch on A is rejected
        b_up = n_up; b_dn = n_dn; b_er = n_err;
        enc_a = 1'b1; ticks(3);
        enc_a = 1'b0; ticks(20);
        chki("glitch3_pulses",
             (n_up - b_up) + (n_dn - b_dn) + (n_err - b_er), 0);

        // 4-cycle glitch on A is accepted both ways
        b_up = n_up; b_dn = n_dn;
        sched(2'b10); ticks(4);
        sched(2'b00); ticks(20);
        chki("glitch4_downs", n_dn - b_dn, 1);
        chki("glitch4_ups", n_up - b_up, 1);

        // Double step errors and sticky flag handling
        b_up = n_up; b_dn = n_dn; b_er = n_err;
        sched(2'b11); ticks(20);
        chki("err1_count", n_err - b_er, 1);
        chk1("err1_flag", err_flag, 1'b1);
        sched(2'b00); ticks(LAT - 1);
        err_clr = 1'b1; ticks(1);
        err_clr = 1'b0; ticks(20);
        chki("err2_count", n_err - b_er, 2);
        chk1("err2_flag_wins", err_flag, 1'b1);
        chki("err_no_steps", (n_up - b_up) + (n_dn - b_dn), 0);
        err_clr = 1'b1; ticks(1);
        err_clr = 1'b0; ticks(5);
        chk1("flag_cleared", err_flag, 1'b0);

        // Reset before a pending pulse is delivered
        sched(2'b10); ticks(20);
        sched(2'b01); ticks(20);
        chk1("pre_rst_flag", err_flag, 1'b1);
        chk1("pre_rst_dir", dir, 1'b0);
        b_up = n_up;
        sched(2'b11); ticks(2);
        assert_reset();
        ticks(3);
        release_reset();
        ticks(20);
        chki("rst_no_up", n_up - b_up, 0);
        chk2("rst_reprime_phase", phase, 2'b11);
        b_up = n_up;
        sched(2'b10); ticks(20);
        chki("post_rst_up", n_up - b_up, 1);

        // Random walk with occasional double steps, en and err_clr
        for (int k = 0; k < 300; k++) begin
            rr = $urandom_range(0, 19);
            delta = (rr < 9) ? 1 : (rr < 18) ? 3 : 2;
            en = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(4, 12);
            sched(seq[(gidx(m_enc) + delta) % 4]);
            if ($urandom_range(0, 7) == 0) begin
                err_clr = 1'b1; ticks(1);
                err_clr = 1'b0; ticks(gap - 1);
            end else begin
                ticks(gap);
            end
        end
        en = 1'b1;
        ticks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
